// File: rtl/l2_flush_sequencer_pkg.sv
// l2_flush_sequencer_pkg: sequencer state type and default L2 geometry shared by the flush sequencer files
package l2_flush_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} l2_flush_state_t;
   localparam int L2_SETS_DFLT = 256;
   localparam int L2_WAYS_DFLT = 8;
   localparam int N_MSHR_DFLT = 8;
endpackage

// File: rtl/l2_flush_index_counter.sv
// l2_flush_index_counter: nested set/way walk counter with clear, advance and a last-slot flag
module l2_flush_index_counter
   import l2_flush_sequencer_pkg::*;
#(
   parameter int L2_SETS = L2_SETS_DFLT,
   parameter int L2_WAYS = L2_WAYS_DFLT,
   parameter int SET_W = $clog2(L2_SETS),
   parameter int WAY_W = $clog2(L2_WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             adv_i,
   output logic [SET_W-1:0] set_o,
   output logic [WAY_W-1:0] way_o,
   output logic             last_o
);
   logic [SET_W-1:0] set_q, set_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic way_end;
   assign way_end = way_q == WAY_W'(L2_WAYS - 1);
   assign last_o = way_end && set_q == SET_W'(L2_SETS - 1);
   assign set_o = set_q;
   assign way_o = way_q;
   // way steps on every advance; set steps only when the way wraps, and both wrap past the last slot
   always_comb begin
      way_d = clr_i ? '0 : adv_i ? (way_end ? '0 : way_q + WAY_W'(1)) : way_q;
      set_d = clr_i ? '0 : (adv_i && way_end) ? set_q + SET_W'(1) : set_q;
   end
   // index registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         set_q <= '0;
         way_q <= '0;
      end else begin
         set_q <= set_d;
         way_q <= way_d;
      end
endmodule

// File: rtl/l2_flush_sequencer.sv
// l2_flush_sequencer: walks every L2 (set, way) through the decode stage, then waits for MSHRs to drain; optional stats under L2_FLUSH_STATS_EN
module l2_flush_sequencer
   import l2_flush_sequencer_pkg::*;
#(
   parameter int L2_SETS = L2_SETS_DFLT,
   parameter int L2_WAYS = L2_WAYS_DFLT,
   parameter int N_MSHR = N_MSHR_DFLT,
   parameter int SET_W = $clog2(L2_SETS),
   parameter int WAY_W = $clog2(L2_WAYS),
   parameter int CNT_W = $clog2(N_MSHR) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             l2_flush_valid_int,
   output logic             l2_flush_ready_int,
   input  logic             l2_fwd_in_valid_int,
   input  logic [CNT_W-1:0] mshr_cnt,
   output logic             flush_req,
   input  logic             flush_grant,
   output logic [SET_W-1:0] flush_set,
   output logic [WAY_W-1:0] flush_way,
   output logic             ongoing_flush,
`ifdef L2_FLUSH_STATS_EN
   output logic             flush_done,
   output logic [31:0]      flush_issue_cnt,
   output logic [31:0]      flush_stall_cnt
`else
   output logic             flush_done
`endif
);
   l2_flush_state_t state_q;
   logic ongoing_q, done_q, all_free, accept, adv, last;
   assign all_free = mshr_cnt == CNT_W'(N_MSHR);
   assign l2_flush_ready_int = state_q == IDLE && all_free;
   assign accept = l2_flush_valid_int && l2_flush_ready_int;
   assign flush_req = state_q == SWEEP && !l2_fwd_in_valid_int && |mshr_cnt;
   assign adv = flush_req && flush_grant;
   assign ongoing_flush = ongoing_q;
   assign flush_done = done_q;
   l2_flush_index_counter #(
      .L2_SETS(L2_SETS),
      .L2_WAYS(L2_WAYS),
      .SET_W(SET_W),
      .WAY_W(WAY_W)
   ) u_idx (
      .clk(clk),
      .rst(rst),
      .clr_i(accept),
      .adv_i(adv),
      .set_o(flush_set),
      .way_o(flush_way),
      .last_o(last)
   );
   // sequencer: accept only with all MSHRs free, sweep until the final slot is granted, drain, pulse done
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         ongoing_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (accept) begin
               state_q <= SWEEP;
               ongoing_q <= 1'b1;
            end
            SWEEP: if (adv && last) state_q <= DRAIN;
            DRAIN: if (all_free) begin
               state_q <= DONE;
               done_q <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               ongoing_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
`ifdef L2_FLUSH_STATS_EN
   logic [31:0] issue_q, issue_d, stall_q, stall_d;
   assign flush_issue_cnt = issue_q;
   assign flush_stall_cnt = stall_q;
   // saturating counters, cleared when a new flush is accepted and frozen outside the sweep
   always_comb begin
      issue_d = accept ? '0 : (adv && !(&issue_q)) ? issue_q + 32'd1 : issue_q;
      stall_d = accept ? '0 : (flush_req && !flush_grant && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
   end
   // stats registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         issue_q <= '0;
         stall_q <= '0;
      end else begin
         issue_q <= issue_d;
         stall_q <= stall_d;
      end
`endif
endmodule
